// File: rtl/dlsc_axi_wrcollect.sv
// dlsc_axi_wrcollect: AXI write-burst collector.
// Holds W data locally and releases an AW downstream only once the whole burst
// for that command is buffered. The B channel is a straight wire-through.
// Optional build macro: WRCOLLECT_CHECK_EN enables the sticky burst-length
// mismatch flag err_len. When it is undefined, err_len is tied low.
module dlsc_axi_wrcollect #(
  parameter int unsigned DATA     = 32,
  parameter int unsigned ADDR     = 32,
  parameter int unsigned LEN      = 4,
  parameter int unsigned BUF_ADDR = 4
) (
  input  logic                clk,
  input  logic                rst_n,

  output logic                m_aw_ready,
  input  logic                m_aw_valid,
  input  logic [ADDR-1:0]     m_aw_addr,
  input  logic [LEN-1:0]      m_aw_len,

  output logic                m_w_ready,
  input  logic                m_w_valid,
  input  logic                m_w_last,
  input  logic [DATA-1:0]     m_w_data,
  input  logic [DATA/8-1:0]   m_w_strb,

  input  logic                m_b_ready,
  output logic                m_b_valid,
  output logic [1:0]          m_b_resp,

  input  logic                s_aw_ready,
  output logic                s_aw_valid,
  output logic [ADDR-1:0]     s_aw_addr,
  output logic [LEN-1:0]      s_aw_len,

  input  logic                s_w_ready,
  output logic                s_w_valid,
  output logic                s_w_last,
  output logic [DATA-1:0]     s_w_data,
  output logic [DATA/8-1:0]   s_w_strb,

  output logic                s_b_ready,
  input  logic                s_b_valid,
  input  logic [1:0]          s_b_resp,

  output logic                err_len
);

  localparam int unsigned STRB      = DATA / 8;
  localparam int unsigned CMD_W     = ADDR + LEN;
  localparam int unsigned DAT_W     = 1 + STRB + DATA;
  localparam int unsigned BUF_DEPTH = 1 << BUF_ADDR;
  localparam int unsigned CNT_W     = BUF_ADDR + 1;

  // ---------------------------------------------------------------------------
  // Ready qualifier: holds both upstream readies low during reset and lets
  // them rise on the first clock after release.
  // ---------------------------------------------------------------------------
  logic run;

  // Set once out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) run <= 1'b0;
    else        run <= 1'b1;
  end

  // ---------------------------------------------------------------------------
  // Command FIFO (4 x {addr,len})
  // ---------------------------------------------------------------------------
  logic [CMD_W-1:0] cmd_mem [4];
  logic [1:0]       cmd_wr;
  logic [1:0]       cmd_rd;
  logic [2:0]       cmd_cnt;
  logic             cmd_full;
  logic             cmd_empty;
  logic             cmd_push;
  logic             cmd_pop;

  assign cmd_full   = (cmd_cnt == 3'd4);
  assign cmd_empty  = (cmd_cnt == 3'd0);
  assign m_aw_ready = run && !cmd_full;
  assign cmd_push   = m_aw_valid && m_aw_ready;
  assign cmd_pop    = s_aw_valid && s_aw_ready;

  // Command storage write port.
  always_ff @(posedge clk) begin
    if (cmd_push) cmd_mem[cmd_wr] <= {m_aw_addr, m_aw_len};
  end

  // Command FIFO pointers and occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmd_wr  <= 2'd0;
      cmd_rd  <= 2'd0;
      cmd_cnt <= 3'd0;
    end else begin
      if (cmd_push) cmd_wr <= cmd_wr + 2'd1;
      if (cmd_pop)  cmd_rd <= cmd_rd + 2'd1;
      if (cmd_push && !cmd_pop)      cmd_cnt <= cmd_cnt + 3'd1;
      else if (!cmd_push && cmd_pop) cmd_cnt <= cmd_cnt - 3'd1;
    end
  end

  assign {s_aw_addr, s_aw_len} = cmd_mem[cmd_rd];

  // ---------------------------------------------------------------------------
  // Data FIFO (2^BUF_ADDR x {last,strb,data}), head visible without a pop
  // ---------------------------------------------------------------------------
  logic [DAT_W-1:0]    data_mem [BUF_DEPTH];
  logic [BUF_ADDR-1:0] data_wr;
  logic [BUF_ADDR-1:0] data_rd;
  logic [CNT_W-1:0]    data_cnt;
  logic                data_full;
  logic                data_empty;
  logic                data_push;
  logic                data_pop;

  assign data_full  = (data_cnt == CNT_W'(BUF_DEPTH));
  assign data_empty = (data_cnt == CNT_W'(0));
  assign m_w_ready  = run && !data_full;
  assign data_push  = m_w_valid && m_w_ready;
  assign data_pop   = s_w_valid && s_w_ready;

  // Data storage write port.
  always_ff @(posedge clk) begin
    if (data_push) data_mem[data_wr] <= {m_w_last, m_w_strb, m_w_data};
  end

  // Data FIFO pointers and occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_wr  <= '0;
      data_rd  <= '0;
      data_cnt <= '0;
    end else begin
      if (data_push) data_wr <= data_wr + BUF_ADDR'(1);
      if (data_pop)  data_rd <= data_rd + BUF_ADDR'(1);
      if (data_push && !data_pop)      data_cnt <= data_cnt + CNT_W'(1);
      else if (!data_push && data_pop) data_cnt <= data_cnt - CNT_W'(1);
    end
  end

  assign {s_w_last, s_w_strb, s_w_data} = data_mem[data_rd];

  // ---------------------------------------------------------------------------
  // Burst accounting
  // burst_cnt: bursts fully buffered but not yet commanded downstream.
  // w_credit : bursts commanded downstream whose data has not fully left.
  // ---------------------------------------------------------------------------
  logic [CNT_W-1:0] burst_cnt;
  logic [2:0]       w_credit;
  logic             burst_inc;
  logic             credit_dec;

  assign burst_inc  = data_push && m_w_last;
  assign credit_dec = data_pop && s_w_last;

  // Complete-burst and outstanding-command counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      burst_cnt <= '0;
      w_credit  <= 3'd0;
    end else begin
      if (burst_inc && !cmd_pop)      burst_cnt <= burst_cnt + CNT_W'(1);
      else if (!burst_inc && cmd_pop) burst_cnt <= burst_cnt - CNT_W'(1);
      if (cmd_pop && !credit_dec)      w_credit <= w_credit + 3'd1;
      else if (!cmd_pop && credit_dec) w_credit <= w_credit - 3'd1;
    end
  end

  assign s_aw_valid = !cmd_empty && (burst_cnt != CNT_W'(0)) && (w_credit != 3'd4);
  assign s_w_valid  = !data_empty && (w_credit != 3'd0);

  // ---------------------------------------------------------------------------
  // B channel pass-through
  // ---------------------------------------------------------------------------
  assign m_b_valid = s_b_valid;
  assign m_b_resp  = s_b_resp;
  assign s_b_ready = m_b_ready;

  // ---------------------------------------------------------------------------
  // Optional downstream burst-length checker
  // ---------------------------------------------------------------------------
`ifdef WRCOLLECT_CHECK_EN
  logic [LEN-1:0] len_q [4];
  logic [1:0]     lq_wr;
  logic [1:0]     lq_rd;
  logic [LEN-1:0] beat;
  logic           err_q;

  // Length of each commanded burst, consumed as its data leaves.
  always_ff @(posedge clk) begin
    if (cmd_pop) len_q[lq_wr] <= s_aw_len;
  end

  // Beat counter compares each outgoing beat against its command length.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lq_wr <= 2'd0;
      lq_rd <= 2'd0;
      beat  <= '0;
      err_q <= 1'b0;
    end else begin
      if (cmd_pop) lq_wr <= lq_wr + 2'd1;
      if (data_pop) begin
        if ((beat == len_q[lq_rd]) != s_w_last) err_q <= 1'b1;
        if (s_w_last) begin
          beat  <= '0;
          lq_rd <= lq_rd + 2'd1;
        end else begin
          beat  <= beat + LEN'(1);
        end
      end
    end
  end

  assign err_len = err_q;
`else
  assign err_len = 1'b0;
`endif

endmodule

// File: tb/tb_dlsc_axi_wrcollect.sv
// Self-checking bench for dlsc_axi_wrcollect: table-driven bursts and B vectors,
// plus hand-written sequences for partial bursts, back-pressure, length errors
// and mid-stream reset.
module tb_dlsc_axi_wrcollect;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        m_aw_ready, m_aw_valid;
  logic [31:0] m_aw_addr;
  logic [3:0]  m_aw_len;
  logic        m_w_ready, m_w_valid, m_w_last;
  logic [31:0] m_w_data;
  logic [3:0]  m_w_strb;
  logic        m_b_ready, m_b_valid;
  logic [1:0]  m_b_resp;
  logic        s_aw_ready, s_aw_valid;
  logic [31:0] s_aw_addr;
  logic [3:0]  s_aw_len;
  logic        s_w_ready, s_w_valid, s_w_last;
  logic [31:0] s_w_data;
  logic [3:0]  s_w_strb;
  logic        s_b_ready, s_b_valid;
  logic [1:0]  s_b_resp;
  logic        err_len;

`ifdef WRCOLLECT_CHECK_EN
  localparam logic EXP_ERR = 1'b1;
`else
  localparam logic EXP_ERR = 1'b0;
`endif

  dlsc_axi_wrcollect #(.DATA(32), .ADDR(32), .LEN(4), .BUF_ADDR(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .m_aw_ready(m_aw_ready), .m_aw_valid(m_aw_valid), .m_aw_addr(m_aw_addr), .m_aw_len(m_aw_len),
    .m_w_ready(m_w_ready), .m_w_valid(m_w_valid), .m_w_last(m_w_last), .m_w_data(m_w_data),
    .m_w_strb(m_w_strb),
    .m_b_ready(m_b_ready), .m_b_valid(m_b_valid), .m_b_resp(m_b_resp),
    .s_aw_ready(s_aw_ready), .s_aw_valid(s_aw_valid), .s_aw_addr(s_aw_addr), .s_aw_len(s_aw_len),
    .s_w_ready(s_w_ready), .s_w_valid(s_w_valid), .s_w_last(s_w_last), .s_w_data(s_w_data),
    .s_w_strb(s_w_strb),
    .s_b_ready(s_b_ready), .s_b_valid(s_b_valid), .s_b_resp(s_b_resp),
    .err_len(err_len)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Monitor state, sampled on the falling edge (inputs change only after rising edges).
  int cyc = 0;
  int maw_acc = 0, mw_acc = 0, saw_hs = 0, sw_hs = 0;
  int maw_cyc = -1, mwlast_cyc = -1, saw_rise_cyc = -1, saw_hs_cyc = -1, sw_rise_cyc = -1;
  logic saw_prev = 1'b0, sw_prev = 1'b0;
  logic [35:0] aw_q [$];
  logic [36:0] w_q  [$];

  // Record handshakes that complete at the next rising edge.
  always @(negedge clk) begin
    cyc++;
    if (m_aw_valid && m_aw_ready) begin maw_acc++; maw_cyc = cyc; end
    if (m_w_valid && m_w_ready) begin mw_acc++; if (m_w_last) mwlast_cyc = cyc; end
    if (s_aw_valid && !saw_prev) saw_rise_cyc = cyc;
    if (s_w_valid && !sw_prev)   sw_rise_cyc = cyc;
    saw_prev = s_aw_valid;
    sw_prev  = s_w_valid;
    if (s_aw_valid && s_aw_ready) begin
      saw_hs++; saw_hs_cyc = cyc; aw_q.push_back({s_aw_addr, s_aw_len});
    end
    if (s_w_valid && s_w_ready) begin
      sw_hs++; w_q.push_back({s_w_last, s_w_strb, s_w_data});
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: timed out waiting for handshake", name);
  endtask

  task automatic tick();
    @(negedge clk); #1;
  endtask

  task automatic to_drive();
    @(posedge clk); #2;
  endtask

  task automatic drive_aw(input logic [31:0] a, input logic [3:0] l);
    bit ok = 1'b0;
    m_aw_valid = 1'b1; m_aw_addr = a; m_aw_len = l;
    for (int i = 0; i < 400 && !ok; i++) begin
      tick();
      ok = m_aw_ready;
    end
    if (!ok) timeout("aw_accept");
    to_drive();
    m_aw_valid = 1'b0;
  endtask

  task automatic drive_w(input logic [31:0] d, input logic [3:0] s, input logic l);
    bit ok = 1'b0;
    m_w_valid = 1'b1; m_w_data = d; m_w_strb = s; m_w_last = l;
    for (int i = 0; i < 400 && !ok; i++) begin
      tick();
      ok = m_w_ready;
    end
    if (!ok) timeout("w_accept");
    to_drive();
    m_w_valid = 1'b0; m_w_last = 1'b0;
  endtask

  task automatic wait_out(input int naw, input int nw);
    bit ok = 1'b0;
    for (int i = 0; i < 300 && !ok; i++) begin
      tick();
      ok = (aw_q.size() >= naw) && (w_q.size() >= nw);
    end
    if (!ok) timeout("downstream_drain");
  endtask

  // Pop one downstream command and its beats, compare against generated data.
  task automatic check_burst(input string name, input logic [31:0] ea, input logic [3:0] el,
                             input int nb, input logic [31:0] dbase);
    logic [35:0] aw;
    logic [36:0] w;
    check({name, "_aw_cnt"}, 64'(aw_q.size() >= 1), 64'd1);
    check({name, "_w_cnt"}, 64'(w_q.size() >= nb), 64'd1);
    if (aw_q.size() >= 1) begin
      aw = aw_q.pop_front();
      check({name, "_aw_addr"}, 64'(aw[35:4]), 64'(ea));
      check({name, "_aw_len"}, 64'(aw[3:0]), 64'(el));
    end
    for (int i = 0; i < nb && w_q.size() > 0; i++) begin
      w = w_q.pop_front();
      check({name, "_beat"}, 64'(w), 64'({(i == nb - 1), 4'(i + 1), dbase + 32'(i)}));
    end
  endtask

  typedef struct {
    logic        aw_first;
    logic [31:0] addr;
    logic [3:0]  len;
    logic [31:0] dbase;
    logic [31:0] exp_addr;
    logic [3:0]  exp_len;
    int          exp_beats;
    int          exp_lat;
  } vec_t;

  typedef struct {
    logic       sv;
    logic [1:0] sr;
    logic       mr;
    logic [3:0] exp;  // {m_b_valid, m_b_resp, s_b_ready}
  } bvec_t;

  vec_t  vt [4];
  bvec_t bt [4];

  initial begin
    int base_aw, base_w, base_saw, base_sw;
    bit ok;

    vt[0] = '{1'b1, 32'h0000_0100, 4'd3,  32'hA000_0000, 32'h0000_0100, 4'd3,  4,  1};
    vt[1] = '{1'b0, 32'h0000_0200, 4'd3,  32'hB000_0000, 32'h0000_0200, 4'd3,  4,  1};
    vt[2] = '{1'b1, 32'h0000_0300, 4'd0,  32'hC000_0000, 32'h0000_0300, 4'd0,  1,  1};
    vt[3] = '{1'b0, 32'h0000_03FC, 4'd15, 32'hD000_0000, 32'h0000_03FC, 4'd15, 16, 1};

    bt[0] = '{1'b1, 2'b00, 1'b1, 4'b1001};
    bt[1] = '{1'b1, 2'b10, 1'b0, 4'b1100};
    bt[2] = '{1'b0, 2'b11, 1'b1, 4'b0111};
    bt[3] = '{1'b1, 2'b01, 1'b0, 4'b1010};

    m_aw_valid = 1'b0; m_aw_addr = '0; m_aw_len = '0;
    m_w_valid = 1'b0; m_w_last = 1'b0; m_w_data = '0; m_w_strb = '0;
    m_b_ready = 1'b0; s_b_valid = 1'b0; s_b_resp = 2'b00;
    s_aw_ready = 1'b1; s_w_ready = 1'b1;

    // Reset state.
    #1 rst_n = 1'b0;
    repeat (3) tick();
    check("rst_m_aw_ready", 64'(m_aw_ready), 64'd0);
    check("rst_m_w_ready", 64'(m_w_ready), 64'd0);
    check("rst_s_aw_valid", 64'(s_aw_valid), 64'd0);
    check("rst_s_w_valid", 64'(s_w_valid), 64'd0);
    check("rst_err_len", 64'(err_len), 64'd0);
    to_drive();
    rst_n = 1'b1;
    tick();
    tick();
    check("post_rst_m_aw_ready", 64'(m_aw_ready), 64'd1);
    check("post_rst_m_w_ready", 64'(m_w_ready), 64'd1);
    to_drive();

    // B pass-through table.
    foreach (bt[k]) begin
      s_b_valid = bt[k].sv; s_b_resp = bt[k].sr; m_b_ready = bt[k].mr;
      #1;
      check("b_pass", 64'({m_b_valid, m_b_resp, s_b_ready}), 64'(bt[k].exp));
      to_drive();
    end
    s_b_valid = 1'b0;

    // Burst table: AW before or after its W data, downstream always ready.
    for (int r = 0; r < 4; r++) begin
      if (vt[r].aw_first) drive_aw(vt[r].addr, vt[r].len);
      for (int i = 0; i < vt[r].exp_beats; i++)
        drive_w(vt[r].dbase + 32'(i), 4'(i + 1), (i == vt[r].exp_beats - 1));
      if (!vt[r].aw_first) drive_aw(vt[r].addr, vt[r].len);
      wait_out(1, vt[r].exp_beats);
      check("vec_aw_latency", 64'(saw_rise_cyc - (vt[r].aw_first ? mwlast_cyc : maw_cyc)),
            64'(vt[r].exp_lat));
      check("vec_w_after_aw", 64'(sw_rise_cyc > saw_hs_cyc), 64'd1);
      check_burst("vec", vt[r].exp_addr, vt[r].exp_len, vt[r].exp_beats, vt[r].dbase);
      repeat (2) tick();
      to_drive();
    end

    // Partial burst holds its command until the last beat arrives.
    base_saw = saw_hs;
    drive_aw(32'h0000_0400, 4'd3);
    for (int i = 0; i < 3; i++) drive_w(32'h1400_0000 + 32'(i), 4'(i + 1), 1'b0);
    repeat (20) tick();
    check("partial_no_aw", 64'(saw_hs - base_saw), 64'd0);
    check("partial_aw_valid", 64'(s_aw_valid), 64'd0);
    to_drive();
    drive_w(32'h1400_0003, 4'd4, 1'b1);
    wait_out(1, 4);
    check("partial_release_lat", 64'(saw_rise_cyc - mwlast_cyc), 64'd1);
    check_burst("partial", 32'h0000_0400, 4'd3, 4, 32'h1400_0000);
    to_drive();

    // Back-pressure: data buffer and command credit saturate.
    s_w_ready = 1'b0;
    base_aw = maw_acc; base_w = mw_acc; base_saw = saw_hs;
    for (int i = 0; i < 4; i++) drive_aw(32'h0000_1000 + 32'(i * 64), 4'd3);
    tick();
    check("bp_aw_full", 64'(m_aw_ready), 64'd0);
    to_drive();
    fork
      drive_aw(32'h0000_1100, 4'd3);
      begin
        for (int i = 0; i < 20; i++)
          drive_w(32'h2000_0000 + 32'(i), 4'(i % 4 + 1), (i % 4 == 3));
      end
    join_none
    repeat (60) tick();
    check("bp_w_accepted", 64'(mw_acc - base_w), 64'd16);
    check("bp_w_ready_low", 64'(m_w_ready), 64'd0);
    check("bp_aw_accepted", 64'(maw_acc - base_aw), 64'd5);
    check("bp_s_aw_issued", 64'(saw_hs - base_saw), 64'd4);
    check("bp_s_aw_stalled", 64'(s_aw_valid), 64'd0);
    to_drive();
    s_w_ready = 1'b1;
    wait fork;
    wait_out(5, 20);
    for (int b = 0; b < 5; b++) begin
      logic [35:0] aw;
      logic [36:0] w;
      if (aw_q.size() > 0) begin
        aw = aw_q.pop_front();
        check("bp_aw_addr", 64'(aw[35:4]), 64'(32'h0000_1000 + 32'(b * 64)));
      end
      for (int i = 0; i < 4 && w_q.size() > 0; i++) begin
        w = w_q.pop_front();
        check("bp_beat", 64'(w), 64'({(i == 3), 4'(i + 1), 32'h2000_0000 + 32'(b * 4 + i)}));
      end
    end
    to_drive();

    // Over-long burst: err_len rises after the second downstream beat (check builds).
    base_sw = sw_hs;
    drive_aw(32'h0000_0500, 4'd1);
    for (int i = 0; i < 3; i++) drive_w(32'h5000_0000 + 32'(i), 4'(i + 1), (i == 2));
    ok = 1'b0;
    for (int i = 0; i < 100 && !ok; i++) begin
      tick();
      ok = (sw_hs - base_sw) >= 2;
    end
    if (!ok) timeout("len_err_beats");
    check("len_err_before", 64'(err_len), 64'd0);
    tick();
    check("len_err_after", 64'(err_len), 64'(EXP_ERR));
    wait_out(1, 3);
    check_burst("len_err", 32'h0000_0500, 4'd1, 3, 32'h5000_0000);
    repeat (5) tick();
    check("len_err_sticky", 64'(err_len), 64'(EXP_ERR));
    to_drive();

    // Reset with two complete bursts buffered drops everything.
    s_aw_ready = 1'b0;
    drive_aw(32'h0000_0600, 4'd3);
    drive_aw(32'h0000_0700, 4'd3);
    for (int i = 0; i < 8; i++) drive_w(32'h6000_0000 + 32'(i), 4'hF, (i % 4 == 3));
    tick();
    check("pre_rst_aw_valid", 64'(s_aw_valid), 64'd1);
    check("pre_rst_w_valid", 64'(s_w_valid), 64'd0);
    to_drive();
    rst_n = 1'b0;
    #1;
    check("mid_rst_valids", 64'({s_aw_valid, s_w_valid, m_aw_ready, m_w_ready}), 64'd0);
    check("mid_rst_err_len", 64'(err_len), 64'd0);
    repeat (2) tick();
    to_drive();
    s_aw_ready = 1'b1;
    base_saw = saw_hs; base_sw = sw_hs;
    rst_n = 1'b1;
    tick();
    check("release_ready_low", 64'(m_aw_ready), 64'd0);
    tick();
    check("release_ready_high", 64'({m_aw_ready, m_w_ready}), 64'b11);
    repeat (20) tick();
    check("post_rst_no_aw", 64'(saw_hs - base_saw), 64'd0);
    check("post_rst_no_w", 64'(sw_hs - base_sw), 64'd0);
    check("post_rst_idle", 64'({s_aw_valid, s_w_valid}), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dlsc_axi_wrcollect.md
# dlsc_axi_wrcollect

Write-burst collector between the slave side of the AXI reset-crossing stage and a downstream AXI slave. It buffers write data and issues a write command downstream only once that burst's complete W data is held locally. A downstream slave therefore never sees an AW whose data may stall or be lost. The B channel passes straight through.

## Interface
- DATA, 32, data width (multiple of 8)
- ADDR, 32, address width
- LEN, 4, burst length field width (bursts of 1..2^LEN beats)
- BUF_ADDR, 4, W buffer depth is 2^BUF_ADDR beats; BUF_ADDR >= LEN is required
- clk  in  1  single clock; every flop on rising edge
- rst_n  in  1  asynchronous, active-low reset
- m_aw_ready  out  1  AW command accepted from upstream
- m_aw_valid  in  1  upstream AW valid
- m_aw_addr  in  ADDR  upstream AW address
- m_aw_len  in  LEN  upstream AW length (beats-1)
- m_w_ready  out  1  W beat accepted from upstream
- m_w_valid  in  1  upstream W valid
- m_w_last  in  1  upstream W last beat of burst
- m_w_data  in  DATA  upstream W data
- m_w_strb  in  DATA/8  upstream W byte strobes
- m_b_ready  in  1  upstream B ready
- m_b_valid  out  1  B valid to upstream (= s_b_valid)
- m_b_resp  out  2  B response to upstream (= s_b_resp)
- s_aw_ready  in  1  downstream AW ready
- s_aw_valid  out  1  downstream AW valid
- s_aw_addr  out  ADDR  downstream AW address
- s_aw_len  out  LEN  downstream AW length
- s_w_ready  in  1  downstream W ready
- s_w_valid  out  1  downstream W valid
- s_w_last  out  1  downstream W last
- s_w_data  out  DATA  downstream W data
- s_w_strb  out  DATA/8  downstream W strobes
- s_b_ready  out  1  downstream B ready (= m_b_ready)
- s_b_valid  in  1  downstream B valid
- s_b_resp  in  2  downstream B response
- err_len  out  1  sticky burst-length mismatch flag (WRCOLLECT_CHECK_EN builds only; constant 0 otherwise)

## Operation
- Command FIFO: 4 entries of {addr,len}; m_aw_ready = !cmd_full; push on m_aw handshake.
- Data FIFO: 2^BUF_ADDR entries of {last,strb,data}, first-word-fall-through; m_w_ready = !data_full; push on m_w handshake.
- burst_cnt (BUF_ADDR+1 bits): complete bursts buffered but not yet commanded; +1 on accepted m_w beat with m_w_last, -1 on s_aw handshake; simultaneous +1/-1 leaves it unchanged.
- w_credit (3 bits, 0..4): commanded bursts whose data has not fully left; +1 on s_aw handshake, -1 on s_w handshake with s_w_last; simultaneous events cancel.
- s_aw_valid = !cmd_empty && burst_cnt!=0 && w_credit!=4; s_aw_* = cmd FIFO head; pop on handshake.
- s_w_valid = !data_empty && w_credit!=0; s_w_* = data FIFO head; pop on handshake. AW/W order preserved strictly; W may arrive before its AW.
- B channel purely combinational; no state.

## Timing
- Reset (rst_n low, async): FIFOs empty, counters 0, err_len 0; m_aw_ready, m_w_ready, s_aw_valid, s_w_valid all 0 while rst_n low; readies rise first cycle after release. Reset mid-burst drops all buffered commands and data.
- Last W beat accepted in cycle N with AW already buffered -> s_aw_valid in N+1. AW accepted in N with its data already complete -> s_aw_valid in N+1.
- s_aw handshake in cycle N -> s_w_valid no earlier than N+1; then one beat per cycle while s_w_ready high.
- Full FIFO: ready low same cycle occupancy hits depth; push and pop in the same cycle at full is not allowed (ready already low), at empty a push is not visible until next cycle.

## Configuration
- WRCOLLECT_CHECK_EN defined: a 4-entry len queue is pushed on s_aw handshake; output beat counter checks each s_w beat; err_len sets (sticky until reset) when s_w_last occurs at beat != len or beat == len without s_w_last. Data flow unaffected.
- Undefined: no queue or beat counter; err_len tied 0.

## Test plan
- AW{0x100,len=3} then 4 W beats, s ready high -> s_aw_valid one cycle after 4th beat accepted; 4 beats follow in order, s_w_last on beat 4.
- 4 W beats (last on 4th) before AW{0x200,3} -> s_aw_valid cycle after AW accepted; no s_w_valid before s_aw handshake.
- AW{len=3} plus only 3 W beats -> s_aw_valid stays 0 indefinitely; 4th beat releases it next cycle.
- BUF_ADDR=4, s_w_ready=0, 5 AW{len=3} plus 20 beats -> m_w_ready drops after 16 beats, m_aw_ready after 4 AWs; s_aw issues 4 commands then stalls on w_credit=4.
- CHECK_EN build: AW{len=1} with 3 beats (last on 3rd) -> err_len=1 after 2nd downstream beat, held until rst_n low.
- rst_n pulsed low with 2 bursts buffered -> all valids 0 immediately; after release nothing is emitted downstream.
